// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the requester-side and memory-side signals of the memory port arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the CPU/IO/RAM surroundings.
interface mem_bus_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [2:0]          req_valid;
    logic [2:0]          req_we;
    logic [3*ADDR_W-1:0] req_addr;
    logic [3*DATA_W-1:0] req_wdata;
    logic [2:0]          req_ready;
    logic [2:0]          resp_valid;
    logic [DATA_W-1:0]   resp_rdata;
    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic                busy;
    logic [1:0]          grant_id;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, mem_en, mem_we,
               mem_addr, mem_wdata, busy, grant_id
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, mem_en, mem_we,
               mem_addr, mem_wdata, busy, grant_id
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares one memory port between fetch (0), load/store (1) and I/O/DMA (2).
// It handles one transaction at a time. The response is registered and goes back to the winner before the next accept.
module mem_bus_arbiter #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_bus_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

    state_t     state;
    logic [1:0] last_grant;
    logic [1:0] winner;
    logic [1:0] lat_cnt;
    logic       cur_we;

    function automatic logic [1:0] rr_index(input logic [1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= 3) begin
            sum = sum - 3;
        end
        return 2'(sum);
    endfunction

    // Scan from farthest to nearest so the requester closest after last_grant takes priority.
    always_comb begin
        winner = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            if (bus.req_valid[rr_index(last_grant, k)]) begin
                winner = rr_index(last_grant, k);
            end
        end
    end

    always_comb begin
        bus.req_ready = 3'b000;
        if (state == IDLE && bus.req_valid != 3'b000) begin
            bus.req_ready = 3'b001 << winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_grant     <= 2'd2;
            lat_cnt        <= 2'd0;
            cur_we         <= 1'b0;
            bus.resp_valid <= 3'b000;
            bus.resp_rdata <= '0;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.busy       <= 1'b0;
            bus.grant_id   <= 2'd0;
        end else begin
            bus.resp_valid <= 3'b000;
            case (state)
                IDLE: begin
                    if (bus.req_valid != 3'b000) begin
                        cur_we        <= bus.req_we[winner];
                        last_grant    <= winner;
                        bus.grant_id  <= winner;
                        bus.busy      <= 1'b1;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= bus.req_we[winner];
                        bus.mem_addr  <= bus.req_addr[winner*ADDR_W +: ADDR_W];
                        bus.mem_wdata <= bus.req_wdata[winner*DATA_W +: DATA_W];
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.mem_en    <= 1'b0;
                    bus.mem_we    <= 1'b0;
                    bus.mem_addr  <= '0;
                    bus.mem_wdata <= '0;
                    if (cur_we) begin
                        bus.resp_valid <= 3'b001 << bus.grant_id;
                        bus.resp_rdata <= '0;
                        state          <= RESP;
                    end else begin
                        lat_cnt <= LAT_INIT;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // The last WAIT cycle is MEM_LAT cycles after ISSUE, when the read data is valid.
                    if (lat_cnt == 2'd0) begin
                        bus.resp_valid <= 3'b001 << bus.grant_id;
                        bus.resp_rdata <= bus.mem_rdata;
                        state          <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                RESP: begin
                    bus.resp_rdata <= '0;
                    bus.busy       <= 1'b0;
                    bus.grant_id   <= 2'd0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter, with one instance at MEM_LAT=1 and one at MEM_LAT=4.
// The directed stimulus pushes expected responses and a monitor pops and compares them.
module tb_mem_bus_arbiter;
    typedef struct {
        logic [2:0]  strobe;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    exp_t q1[$];
    exp_t q4[$];

    mem_bus_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus1();
    mem_bus_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus4();

    mem_bus_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );
    mem_bus_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_model(input logic [15:0] a);
        case (a)
            16'h0010: return 16'hBEEF;
            16'hFFFF: return 16'hA5A5;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    // Memory models drive the read data only in the cycle it is valid. Every other cycle carries 0xDEAD.
    logic [15:0] rd1;
    logic [15:0] p4 [4];
    always @(posedge clk) begin
        rd1   <= (bus1.mem_en && !bus1.mem_we) ? mem_model(bus1.mem_addr) : 16'hDEAD;
        p4[0] <= (bus4.mem_en && !bus4.mem_we) ? mem_model(bus4.mem_addr) : 16'hDEAD;
        p4[1] <= p4[0];
        p4[2] <= p4[1];
        p4[3] <= p4[2];
    end
    assign bus1.mem_rdata = rd1;
    assign bus4.mem_rdata = p4[3];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void push(input bit sel4, input logic [2:0] strobe, input logic [15:0] data);
        exp_t e;
        e.strobe = strobe;
        e.data   = data;
        if (sel4) q4.push_back(e);
        else      q1.push_back(e);
    endfunction

    // Waits (bounded) for an accept cycle and checks which requester was granted.
    task automatic checkOutput(input bit sel4, input logic [2:0] exp_ready, input string name);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            r = sel4 ? bus4.req_ready : bus1.req_ready;
            if (r != 3'b000) break;
        end
        check(name, 32'(r), 32'(exp_ready));
    endtask

    task automatic applyStimulus(input bit sel4, input int id, input logic we,
                                 input logic [15:0] addr, input logic [15:0] wdata);
        if (sel4) begin
            bus4.req_valid[id]           = 1'b1;
            bus4.req_we[id]              = we;
            bus4.req_addr[id*16 +: 16]   = addr;
            bus4.req_wdata[id*16 +: 16]  = wdata;
        end else begin
            bus1.req_valid[id]           = 1'b1;
            bus1.req_we[id]              = we;
            bus1.req_addr[id*16 +: 16]   = addr;
            bus1.req_wdata[id*16 +: 16]  = wdata;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response strobe is compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus1.resp_valid != 3'b000) begin
                if (q1.size() == 0) begin
                    check("unexpected resp1", 32'(bus1.resp_valid), 32'd0);
                end else begin
                    e = q1.pop_front();
                    check("resp1 strobe", 32'(bus1.resp_valid), 32'(e.strobe));
                    check("resp1 data", 32'(bus1.resp_rdata), 32'(e.data));
                end
            end
            if (bus4.resp_valid != 3'b000) begin
                if (q4.size() == 0) begin
                    check("unexpected resp4", 32'(bus4.resp_valid), 32'd0);
                end else begin
                    e = q4.pop_front();
                    check("resp4 strobe", 32'(bus4.resp_valid), 32'(e.strobe));
                    check("resp4 data", 32'(bus4.resp_rdata), 32'(e.data));
                end
            end
        end
    end

    initial begin
        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        bus1.req_valid = '0; bus1.req_we = '0; bus1.req_addr = '0; bus1.req_wdata = '0;
        bus4.req_valid = '0; bus4.req_we = '0; bus4.req_addr = '0; bus4.req_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(bus1.busy), 32'd0);
        check("reset mem_en", 32'(bus1.mem_en), 32'd0);
        check("reset resp_valid", 32'(bus1.resp_valid), 32'd0);
        check("reset grant_id", 32'(bus1.grant_id), 32'd0);
        check("reset ready", 32'(bus1.req_ready), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        repeat (2) next_cycle();

        $display("[TB] single read, requester 0, latency 1");
        applyStimulus(1'b0, 0, 1'b0, 16'h0010, 16'h0000);
        checkOutput(1'b0, 3'b001, "t1 ready");
        push(1'b0, 3'b001, 16'hBEEF);
        next_cycle();
        bus1.req_valid = 3'b000;
        @(negedge clk);
        check("t1 mem_en T+1", 32'(bus1.mem_en), 32'd1);
        check("t1 mem_addr T+1", 32'(bus1.mem_addr), 32'h0010);
        check("t1 mem_we T+1", 32'(bus1.mem_we), 32'd0);
        check("t1 busy T+1", 32'(bus1.busy), 32'd1);
        @(negedge clk);
        check("t1 mem_en T+2", 32'(bus1.mem_en), 32'd0);
        check("t1 mem_addr T+2", 32'(bus1.mem_addr), 32'd0);
        @(negedge clk);
        check("t1 resp T+3", 32'(bus1.resp_valid), 32'b001);
        @(negedge clk);
        check("t1 busy T+4", 32'(bus1.busy), 32'd0);

        $display("[TB] write, requester 1");
        next_cycle();
        applyStimulus(1'b0, 1, 1'b1, 16'h7FFF, 16'h1234);
        checkOutput(1'b0, 3'b010, "t2 ready");
        push(1'b0, 3'b010, 16'h0000);
        next_cycle();
        bus1.req_valid = 3'b000;
        @(negedge clk);
        check("t2 mem_en T+1", 32'(bus1.mem_en), 32'd1);
        check("t2 mem_we T+1", 32'(bus1.mem_we), 32'd1);
        check("t2 mem_addr T+1", 32'(bus1.mem_addr), 32'h7FFF);
        check("t2 mem_wdata T+1", 32'(bus1.mem_wdata), 32'h1234);
        check("t2 grant_id T+1", 32'(bus1.grant_id), 32'd1);
        @(negedge clk);
        check("t2 resp T+2", 32'(bus1.resp_valid), 32'b010);
        @(negedge clk);
        check("t2 busy T+3", 32'(bus1.busy), 32'd0);

        $display("[TB] requesters 1 and 2 after a grant to 1");
        next_cycle();
        applyStimulus(1'b0, 1, 1'b0, 16'h0020, 16'h0000);
        applyStimulus(1'b0, 2, 1'b0, 16'h0030, 16'h0000);
        checkOutput(1'b0, 3'b100, "rr first 2");
        push(1'b0, 3'b100, mem_model(16'h0030));
        next_cycle();
        bus1.req_valid[2] = 1'b0;
        checkOutput(1'b0, 3'b010, "rr then 1");
        push(1'b0, 3'b010, mem_model(16'h0020));
        next_cycle();
        bus1.req_valid = 3'b000;
        repeat (6) next_cycle();

        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        $display("[TB] all three valid continuously");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, i, 1'b0, 16'h0100 + 16'(i), 16'h0000);
        end
        for (int k = 0; k < 6; k++) begin
            checkOutput(1'b0, 3'b001 << (k % 3), $sformatf("rr6 grant %0d", k));
            push(1'b0, 3'b001 << (k % 3), mem_model(16'h0100 + 16'(k % 3)));
            next_cycle();
            if (k == 5) bus1.req_valid = 3'b000;
        end
        repeat (6) next_cycle();

        $display("[TB] latency 4 read, requester 2");
        applyStimulus(1'b1, 2, 1'b0, 16'hFFFF, 16'h0000);
        checkOutput(1'b1, 3'b100, "t4 ready");
        push(1'b1, 3'b100, 16'hA5A5);
        next_cycle();
        bus4.req_valid = 3'b000;
        @(negedge clk);
        check("t4 mem_en T+1", 32'(bus4.mem_en), 32'd1);
        check("t4 mem_addr T+1", 32'(bus4.mem_addr), 32'hFFFF);
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("t4 mem_en T+%0d", c), 32'(bus4.mem_en), 32'd0);
            check($sformatf("t4 no resp T+%0d", c), 32'(bus4.resp_valid), 32'd0);
        end
        @(negedge clk);
        check("t4 resp T+6", 32'(bus4.resp_valid), 32'b100);
        @(negedge clk);
        check("t4 busy T+7", 32'(bus4.busy), 32'd0);

        $display("[TB] reset during WAIT");
        next_cycle();
        applyStimulus(1'b1, 1, 1'b0, 16'h0200, 16'h0000);
        checkOutput(1'b1, 3'b010, "rst ready");
        next_cycle();
        bus4.req_valid = 3'b000;
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        #1;
        check("rst busy", 32'(bus4.busy), 32'd0);
        check("rst mem_en", 32'(bus4.mem_en), 32'd0);
        check("rst grant_id", 32'(bus4.grant_id), 32'd0);
        check("rst resp_valid", 32'(bus4.resp_valid), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("rst no late resp", 32'(bus4.resp_valid), 32'd0);
        end
        next_cycle();
        applyStimulus(1'b1, 0, 1'b0, 16'h0300, 16'h0000);
        applyStimulus(1'b1, 1, 1'b0, 16'h0200, 16'h0000);
        checkOutput(1'b1, 3'b001, "post-rst grant 0");
        push(1'b1, 3'b001, mem_model(16'h0300));
        next_cycle();
        bus4.req_valid[0] = 1'b0;
        checkOutput(1'b1, 3'b010, "post-rst grant 1");
        push(1'b1, 3'b010, mem_model(16'h0200));
        next_cycle();
        bus4.req_valid = 3'b000;
        repeat (12) next_cycle();

        check("q1 drained", 32'(q1.size()), 32'd0);
        check("q4 drained", 32'(q4.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
